// File: rtl/dco_mtrx_encoder.sv
// ---------------------------------------------------------------------------
// dco_mtrx_encoder
//
// Purpose:
//    Converts the 64-bit DCO matrix thermometer word back into the 8-bit
//    binary DCO code (column in code[7:4], row in code[3:0]).
//    It also performs these checks:
//       - flags samples that break the matrix encoding rules;
//       - flags jumps between consecutive legal codes larger than MAX_STEP;
//       - keeps a saturating count of erroring samples.
//    Two-stage pipeline, one sample per cycle, no backpressure.
//
// Ports:
//    clk        system clock, rising edge
//    rst        asynchronous reset, active-high
//    in_valid   mtrx_thrm is sampled this cycle
//    mtrx_thrm  [63:48] row_p, [47:32] row_n, [31:16] col_on, [15:0] col_off
//    clr_err    synchronous clear of err_cnt and of the step reference
//    out_valid  code / illegal / step_err are valid this cycle
//    code       encoded DCO code
//    illegal    sample violated the matrix encoding rules
//    step_err   jump from the previous legal code exceeded MAX_STEP
//    err_cnt    saturating count of samples with illegal or step_err set
// ---------------------------------------------------------------------------
module dco_mtrx_encoder #(
   parameter int unsigned MAX_STEP = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [63:0]      mtrx_thrm,
   input  logic             clr_err,
   output logic             out_valid,
   output logic [7:0]       code,
   output logic             illegal,
   output logic             step_err,
   output logic [CNT_W-1:0] err_cnt
);

   // ------------------------------------------------------------------
   // Stage 1: input register
   // ------------------------------------------------------------------
   logic        s1_valid_q, s1_valid_d;
   logic [63:0] s1_thrm_q,  s1_thrm_d;

   always_comb begin
      s1_valid_d = in_valid;
      // Hold the data register when idle so it does not toggle needlessly.
      s1_thrm_d  = in_valid ? mtrx_thrm : s1_thrm_q;
   end

   // ------------------------------------------------------------------
   // Stage 1: priority encodes and legality checks on the registered word
   // ------------------------------------------------------------------
   logic [15:0] row_p, row_n, col_on, col_off;
   logic [15:0] row_n_inv;
   logic [3:0]  col_idx;
   logic [3:0]  p_r;
   logic [3:0]  n_zero_idx;
   logic [3:0]  n_r;
   logic        col_even;
   logic        col_ok, off_ok, p_ok, n_ok;
   logic [7:0]  s1_code;
   logic        s1_illegal;

   always_comb begin
      row_p      = s1_thrm_q[63:48];
      row_n      = s1_thrm_q[47:32];
      col_on     = s1_thrm_q[31:16];
      col_off    = s1_thrm_q[15:0];
      row_n_inv  = ~row_n;

      col_idx    = 4'd0;
      p_r        = 4'd0;
      n_zero_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (col_on[i]) begin
            col_idx = 4'(i);
         end
         // highest set bit of row_p plus one; row_p == 16'hFFFF wraps to 0
         if (row_p[i]) begin
            p_r = 4'(i + 1);
         end
         if (!row_n[i]) begin
            n_zero_idx = 4'(i);
         end
      end

      // row_n all ones has no zero bit and decodes to row 0
      n_r      = (row_n == 16'hFFFF) ? 4'd0 : (4'd15 - n_zero_idx);
      col_even = ~col_idx[0];
      s1_code  = {col_idx, (col_even ? p_r : n_r)};

      // x & (x + 1) == 0 holds exactly when x is a run of ones from bit 0
      // (including 0 and all ones, which are handled separately below).
      col_ok = (col_on != 16'd0) && ((col_on & (col_on + 16'd1)) == 16'd0);
      off_ok = (col_off == ~col_on);
      p_ok   = ((row_p & (row_p + 16'd1)) == 16'd0) && (row_p != 16'hFFFF);
      // row_n fills from bit 15 downward, so its inverse fills from bit 0
      n_ok   = ((row_n_inv & (row_n_inv + 16'd1)) == 16'd0);

      s1_illegal = !(col_ok && off_ok && (col_even ? p_ok : n_ok));
   end

   // ------------------------------------------------------------------
   // Stage 2: output registers, step tracking and error counter
   // ------------------------------------------------------------------
   logic             out_valid_q, out_valid_d;
   logic [7:0]       code_q,      code_d;
   logic             illegal_q,   illegal_d;
   logic             step_err_q,  step_err_d;
   logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
   logic [7:0]       ref_code_q,  ref_code_d;
   logic             ref_vld_q,   ref_vld_d;
   logic [7:0]       code_diff;
   logic             step_hit;

   always_comb begin
      code_diff = (s1_code >= ref_code_q) ? (s1_code - ref_code_q)
                                          : (ref_code_q - s1_code);
      step_hit  = !s1_illegal && ref_vld_q && (code_diff > 8'(MAX_STEP));

      out_valid_d = 1'b0;
      code_d      = code_q;
      illegal_d   = illegal_q;
      step_err_d  = step_err_q;
      err_cnt_d   = err_cnt_q;
      ref_code_d  = ref_code_q;
      ref_vld_d   = ref_vld_q;

      if (s1_valid_q) begin
         out_valid_d = 1'b1;
         code_d      = s1_code;
         illegal_d   = s1_illegal;
         step_err_d  = step_hit;
         if ((s1_illegal || step_hit) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
         // Illegal samples never move the reference.
         if (!s1_illegal) begin
            ref_code_d = s1_code;
            ref_vld_d  = 1'b1;
         end
      end

      // The clear overrides any increment or reference update this cycle.
      if (clr_err) begin
         err_cnt_d = '0;
         ref_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_thrm_q   <= '0;
         out_valid_q <= 1'b0;
         code_q      <= '0;
         illegal_q   <= 1'b0;
         step_err_q  <= 1'b0;
         err_cnt_q   <= '0;
         ref_code_q  <= '0;
         ref_vld_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_thrm_q   <= s1_thrm_d;
         out_valid_q <= out_valid_d;
         code_q      <= code_d;
         illegal_q   <= illegal_d;
         step_err_q  <= step_err_d;
         err_cnt_q   <= err_cnt_d;
         ref_code_q  <= ref_code_d;
         ref_vld_q   <= ref_vld_d;
      end
   end

   assign out_valid = out_valid_q;
   assign code      = code_q;
   assign illegal   = illegal_q;
   assign step_err  = step_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dco_mtrx_encoder.sv
// ---------------------------------------------------------------------------
// tb_dco_mtrx_encoder
//
// Two instances share all inputs:
//    u_dut   default parameters (CNT_W = 8)
//    u_dut2  CNT_W = 2, to exercise counter saturation
//
// A transaction-level model decodes each sample by rebuilding the legal matrix
// word for the decoded code and comparing it with the sample. The model also
// tracks the step reference and both saturating counters.
// ---------------------------------------------------------------------------
module tb_dco_mtrx_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] mtrx_thrm = '0;
   logic        clr_err = 1'b0;

   logic        out_valid,  illegal,  step_err;
   logic [7:0]  code;
   logic [7:0]  err_cnt;
   logic        out_valid2, illegal2, step_err2;
   logic [7:0]  code2;
   logic [1:0]  err_cnt2;

   dco_mtrx_encoder u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mtrx_thrm(mtrx_thrm),
      .clr_err(clr_err), .out_valid(out_valid), .code(code),
      .illegal(illegal), .step_err(step_err), .err_cnt(err_cnt)
   );

   dco_mtrx_encoder #(.MAX_STEP(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mtrx_thrm(mtrx_thrm),
      .clr_err(clr_err), .out_valid(out_valid2), .code(code2),
      .illegal(illegal2), .step_err(step_err2), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit          m_s1_v   = 1'b0;
   logic [63:0] m_s1_d   = '0;
   int          m_ref    = 0;
   bit          m_ref_v  = 1'b0;
   int          m_cnt8   = 0;
   int          m_cnt2   = 0;
   bit          e_ov     = 1'b0;
   int          e_code   = 0;
   bit          e_ill    = 1'b0;
   bit          e_step   = 1'b0;

   function automatic logic [63:0] mk(input logic [15:0] rp, input logic [15:0] rn,
                                      input logic [15:0] con, input logic [15:0] coff);
      return {rp, rn, con, coff};
   endfunction

   // Legal matrix word for code v; the unused row vector gets random bits.
   function automatic logic [63:0] enc(input int v);
      int c;
      int r;
      logic [15:0] con, rp, rn;
      c   = v / 16;
      r   = v % 16;
      con = 16'((32'd2 << c) - 32'd1);
      rp  = 16'($urandom);
      rn  = 16'($urandom);
      if (c % 2 == 0) rp = 16'((32'd1 << r) - 32'd1);
      else            rn = 16'(((32'd1 << r) - 32'd1) << (16 - r));
      return {rp, rn, con, ~con};
   endfunction

   function automatic void dec(input logic [63:0] m, output int cd, output bit ill);
      logic [15:0] rp, rn, con, coff;
      int c;
      int r;
      int z;
      bit row_ok;
      rp   = m[63:48];
      rn   = m[47:32];
      con  = m[31:16];
      coff = m[15:0];
      c = 0;
      r = 0;
      z = -1;
      for (int i = 0; i < 16; i++) if (con[i]) c = i;
      if (c % 2 == 0) begin
         for (int i = 0; i < 16; i++) if (rp[i]) r = i + 1;
         row_ok = (r < 16) && (rp == 16'((32'd1 << r) - 32'd1));
      end else begin
         for (int i = 0; i < 16; i++) if (!rn[i]) z = i;
         r = (z < 0) ? 0 : 15 - z;
         row_ok = (rn == 16'hFFFF) ||
                  (rn == 16'(((32'd1 << r) - 32'd1) << (16 - r)));
      end
      ill = !((con == 16'((32'd2 << c) - 32'd1)) && (coff == ~con) && row_ok);
      cd  = c * 16 + (r % 16);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid",  32'(out_valid),  32'(e_ov));
      chk("code",       32'(code),       32'(e_code));
      chk("illegal",    32'(illegal),    32'(e_ill));
      chk("step_err",   32'(step_err),   32'(e_step));
      chk("err_cnt",    32'(err_cnt),    32'(m_cnt8));
      chk("out_valid2", 32'(out_valid2), 32'(e_ov));
      chk("code2",      32'(code2),      32'(e_code));
      chk("illegal2",   32'(illegal2),   32'(e_ill));
      chk("step_err2",  32'(step_err2),  32'(e_step));
      chk("err_cnt2",   32'(err_cnt2),   32'(m_cnt2));
   endtask

   // One clock: drive inputs, advance the model at the edge, check outputs.
   task automatic cyc(input bit v, input logic [63:0] d, input bit clr);
      int  c;
      bit  il;
      bit  st;
      int  diff;
      in_valid  = v;
      mtrx_thrm = d;
      clr_err   = clr;
      @(posedge clk);
      if (m_s1_v) begin
         dec(m_s1_d, c, il);
         diff = c - m_ref;
         if (diff < 0) diff = -diff;
         st = !il && m_ref_v && (diff > 8);
         e_ov = 1'b1; e_code = c; e_ill = il; e_step = st;
         if (il || st) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
         end
         if (!il) begin
            m_ref   = c;
            m_ref_v = 1'b1;
         end
      end else begin
         e_ov = 1'b0;
      end
      if (clr) begin
         m_cnt8  = 0;
         m_cnt2  = 0;
         m_ref_v = 1'b0;
      end
      m_s1_v = v;
      m_s1_d = d;
      #1;
      if (e_ov)
         $display("[TB] out code=%0d illegal=%0d step_err=%0d err_cnt=%0d err_cnt2=%0d",
                  code, illegal, step_err, err_cnt, err_cnt2);
      check_all();
   endtask

   // Single sample followed by one idle cycle; the output is then on the port.
   task automatic one(input string tag, input logic [63:0] d,
                      input int exp_code, input bit exp_ill);
      cyc(1'b1, d, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk({tag, "_code"}, 32'(code), 32'(exp_code));
      chk({tag, "_ill"},  32'(illegal), 32'(exp_ill));
   endtask

   initial begin
      int v;
      int prv;
      logic [63:0] d;
      logic [63:0] bad5;
      bad5 = mk(16'h0000, 16'h0000, 16'h0005, 16'hFFFA);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // loopback sweep 0..255, in_valid held high
      for (int i = 0; i < 256; i++) begin
         cyc(1'b1, enc(i), 1'b0);
         if (i >= 1) begin
            chk("sweep_code", 32'(code), 32'(i - 1));
            chk("sweep_cnt",  32'(err_cnt), 32'd0);
         end
      end
      cyc(1'b0, '0, 1'b0);
      chk("sweep_last", 32'(code), 32'd255);
      chk("sweep_step", 32'(step_err), 32'd0);
      cyc(1'b0, '0, 1'b1);

      // directed legal patterns
      one("d19",  mk(16'h0000, 16'hE000, 16'h0003, 16'hFFFC), 19,  1'b0);
      one("d120", mk(16'h0000, 16'hFF00, 16'h00FF, 16'hFF00), 120, 1'b0);
      one("d250", mk(16'h0000, 16'hFFC0, 16'hFFFF, 16'h0000), 250, 1'b0);
      one("d32",  mk(16'h0000, 16'h0000, 16'h0007, 16'hFFF8), 32,  1'b0);

      // illegal patterns
      one("i_col5",   bad5, 32, 1'b1);
      one("i_col0",   mk(16'h0000, 16'h0000, 16'h0000, 16'hFFFF), 0,  1'b1);
      one("i_off",    mk(16'h0000, 16'hE000, 16'h0003, 16'hFFFF), 19, 1'b1);
      one("i_rowp",   mk(16'h0005, 16'h0000, 16'h0007, 16'hFFF8), 35, 1'b1);
      one("i_rowpff", mk(16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE), 0,  1'b1);

      // step check: 16, 24, 33
      cyc(1'b0, '0, 1'b1);
      cyc(1'b1, enc(16), 1'b0);
      cyc(1'b1, enc(24), 1'b0);
      chk("step16", 32'(step_err), 32'd0);
      cyc(1'b1, enc(33), 1'b0);
      chk("step24", 32'(step_err), 32'd0);
      cyc(1'b0, '0, 1'b0);
      chk("step33", 32'(step_err), 32'd1);
      chk("step_cnt", 32'(err_cnt), 32'd1);

      // illegal sample between 24 and 30 leaves the reference at 24
      cyc(1'b0, '0, 1'b1);
      cyc(1'b1, enc(24), 1'b0);
      cyc(1'b1, bad5, 1'b0);
      cyc(1'b1, enc(30), 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("ref_hold_code", 32'(code), 32'd30);
      chk("ref_hold_step", 32'(step_err), 32'd0);

      // saturation: five illegal samples
      cyc(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, bad5, 1'b0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("sat_cnt2", 32'(err_cnt2), 32'd3);
      chk("sat_cnt8", 32'(err_cnt), 32'd5);

      // clear coincides with an erroring output: clear wins
      cyc(1'b1, bad5, 1'b0);
      cyc(1'b0, '0, 1'b1);
      chk("clr_ill", 32'(illegal), 32'd1);
      chk("clr_cnt", 32'(err_cnt), 32'd0);
      cyc(1'b1, enc(200), 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("clr_step", 32'(step_err), 32'd0);
      chk("clr_code", 32'(code), 32'd200);

      // randomized traffic
      prv = 128;
      for (int i = 0; i < 800; i++) begin
         v = prv + int'($urandom_range(0, 24)) - 12;
         if (v < 0)   v = 0;
         if (v > 255) v = 255;
         prv = v;
         d = enc(v);
         case ($urandom_range(0, 9))
            0:       d = d ^ (64'd1 << $urandom_range(0, 63));
            1:       d = {$urandom, $urandom};
            default: ;
         endcase
         cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 59) == 0);
      end
      // force some counted errors so the reset test sees a nonzero count
      for (int i = 0; i < 3; i++) cyc(1'b1, bad5, 1'b0);

      // asynchronous reset with two samples in flight
      cyc(1'b1, enc(100), 1'b0);
      in_valid  = 1'b1;
      mtrx_thrm = enc(110);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      in_valid = 1'b0;
      m_s1_v = 1'b0; m_ref_v = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      e_ov = 1'b0; e_code = 0; e_ill = 1'b0; e_step = 1'b0;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
      cyc(1'b1, enc(5), 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("post_rst_code", 32'(code), 32'd5);
      chk("post_rst_step", 32'(step_err), 32'd0);
      cyc(1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
